// File: rtl/alu_seq_if.sv
// Memory handshake bus between the ALU sequencer (master) and the memory (slave).
interface alu_seq_if;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  modport master (output mem_req, mem_we, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/alu_seq.sv
// Sequencer for a 6502-style external ALU: operand fetch, one-cycle execute, flag/accumulator/memory writeback.
// Optional ALU_SEQ_DUMMY_WRITE_EN: memory read-modify-write first writes back the original operand.
module alu_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] op,
  input  logic       use_mem,
  input  logic [7:0] imm,
  input  logic [7:0] acc,
  alu_seq_if.master  mem_bus,
  output logic [7:0] alu_a,
  output logic [7:0] alu_mem,
  output logic       subtract,
  output logic       target_bus,
  output logic       carry_in,
  output logic       sum_sel,
  output logic       and_sel,
  output logic       xor_sel,
  output logic       or_sel,
  output logic       asl_sel,
  output logic       lsr_sel,
  output logic       rol_sel,
  output logic       ror_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_negative,
  output logic       acc_we,
  output logic [7:0] acc_wdata,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_ASL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
`ifdef ALU_SEQ_DUMMY_WRITE_EN
    WRITE_PRE,
`endif
    WRITE,
    DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] op_q;
  logic       use_mem_q;
  logic [7:0] result_q;
  logic       err_q;
  logic [7:0] wait_cnt;
  logic       op_illegal;
  logic       shift_op;
  logic       rmw_op;
  logic       wait_expired;

  assign op_illegal   = (op > OP_CMP);
  assign shift_op     = (op_q inside {OP_ASL, OP_LSR, OP_ROL, OP_ROR});
  assign rmw_op       = shift_op && use_mem_q;
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign acc_wdata    = result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_illegal)   state_next = DONE;
          else if (use_mem) state_next = READ;
          else              state_next = EXEC;
        end
      end
      READ: begin
        if (mem_bus.mem_ack)   state_next = EXEC;
        else if (wait_expired) state_next = DONE;
      end
      EXEC: begin
        if (rmw_op) begin
`ifdef ALU_SEQ_DUMMY_WRITE_EN
          state_next = WRITE_PRE;
`else
          state_next = WRITE;
`endif
        end else begin
          state_next = DONE;
        end
      end
`ifdef ALU_SEQ_DUMMY_WRITE_EN
      WRITE_PRE: begin
        if (mem_bus.mem_ack)   state_next = WRITE;
        else if (wait_expired) state_next = DONE;
      end
`endif
      WRITE: begin
        if (mem_bus.mem_ack || wait_expired) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mem_req is high exactly in the handshake states, so it also gates the wait counter and timeout error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= 4'd0;
      use_mem_q <= 1'b0;
      alu_a     <= 8'h00;
      alu_mem   <= 8'h00;
      result_q  <= 8'h00;
      err_q     <= 1'b0;
      wait_cnt  <= 8'd0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      if (mem_bus.mem_req && !mem_bus.mem_ack && !wait_expired) wait_cnt <= wait_cnt + 8'd1;
      else                                                     wait_cnt <= 8'd0;

      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            use_mem_q <= use_mem;
            alu_a     <= acc;
            alu_mem   <= imm;
            err_q     <= op_illegal;
          end
        end
        READ: begin
          if (mem_bus.mem_ack) alu_mem <= mem_bus.mem_rdata;
        end
        EXEC: begin
          result_q <= alu_out;
          case (op_q)
            OP_ADC, OP_SBC: begin
              flag_c <= alu_carry;
              flag_z <= alu_zero;
              flag_n <= alu_negative;
              flag_v <= alu_overflow;
            end
            OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
              flag_c <= alu_carry;
              flag_z <= alu_zero;
              flag_n <= alu_negative;
            end
            OP_AND, OP_ORA, OP_EOR: begin
              flag_z <= alu_zero;
              flag_n <= alu_negative;
            end
            default: ;
          endcase
        end
        default: ;
      endcase

      if (mem_bus.mem_req && !mem_bus.mem_ack && wait_expired) err_q <= 1'b1;
    end
  end

  always_comb begin
    mem_bus.mem_req   = 1'b0;
    mem_bus.mem_we    = 1'b0;
    mem_bus.mem_wdata = 8'h00;
    subtract          = 1'b0;
    target_bus        = 1'b0;
    carry_in          = 1'b0;
    sum_sel           = 1'b0;
    and_sel           = 1'b0;
    xor_sel           = 1'b0;
    or_sel            = 1'b0;
    asl_sel           = 1'b0;
    lsr_sel           = 1'b0;
    rol_sel           = 1'b0;
    ror_sel           = 1'b0;
    acc_we            = 1'b0;
    busy              = (state != IDLE);
    done              = (state == DONE);
    err               = (state == DONE) && err_q;
    case (state)
      READ: mem_bus.mem_req = 1'b1;
      EXEC: begin
        target_bus = rmw_op;
        case (op_q)
          OP_ADC: begin sum_sel = 1'b1; carry_in = flag_c; end
          OP_SBC: begin sum_sel = 1'b1; subtract = 1'b1; carry_in = flag_c; end
          OP_CMP: begin sum_sel = 1'b1; subtract = 1'b1; carry_in = 1'b1; end
          OP_AND: and_sel = 1'b1;
          OP_ORA: or_sel  = 1'b1;
          OP_EOR: xor_sel = 1'b1;
          OP_ASL: asl_sel = 1'b1;
          OP_LSR: lsr_sel = 1'b1;
          OP_ROL: begin rol_sel = 1'b1; carry_in = flag_c; end
          OP_ROR: begin ror_sel = 1'b1; carry_in = flag_c; end
          default: ;
        endcase
      end
`ifdef ALU_SEQ_DUMMY_WRITE_EN
      WRITE_PRE: begin
        mem_bus.mem_req   = 1'b1;
        mem_bus.mem_we    = 1'b1;
        mem_bus.mem_wdata = alu_mem;
      end
`endif
      WRITE: begin
        mem_bus.mem_req   = 1'b1;
        mem_bus.mem_we    = 1'b1;
        mem_bus.mem_wdata = result_q;
      end
      DONE: acc_we = !err_q && (op_q != OP_CMP) && !rmw_op;
      default: ;
    endcase
  end

endmodule
